// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters with registered sync, blank, de and start pulses
// decoded from the next position. Define VTG_RUNTIME_CFG_EN to add the runtime active-size port.
module video_timing_gen #(
    parameter int CW        = 12,
    parameter int H_ACTIVE  = 400,
    parameter int H_FP      = 8,
    parameter int H_SYNC    = 1,
    parameter int H_BP      = 14,
    parameter int V_ACTIVE  = 360,
    parameter int V_FP      = 14,
    parameter int V_SYNC    = 1,
    parameter int V_BP      = 19,
    parameter int HSYNC_POL = 1,
    parameter int VSYNC_POL = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
`ifdef VTG_RUNTIME_CFG_EN
    ,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_v_active
`endif
);
    localparam int   W1     = CW + 1;
    localparam int   HPORCH = H_FP + H_SYNC + H_BP;
    localparam int   VPORCH = V_FP + V_SYNC + V_BP;
    localparam int   HT0    = H_ACTIVE + HPORCH;
    localparam int   VT0    = V_ACTIVE + VPORCH;
    localparam logic HS_ACT = (HSYNC_POL != 0);
    localparam logic VS_ACT = (VSYNC_POL != 0);

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("video_timing_gen: porch and sync lengths must be non-zero");
    end
    if (longint'(HT0) > (longint'(1) << CW) || longint'(VT0) > (longint'(1) << CW)) begin : g_bad_total
        $error("video_timing_gen: line or frame total does not fit in CW bits");
    end

    logic [CW-1:0] ha, va, ha_d, va_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [W1-1:0] ht_m1, vt_m1, hs_beg, hs_end, vs_beg, vs_end;
    logic          x_wrap, y_wrap, frame_wrap;
    logic          hsync_q, vsync_q, hblank_q, vblank_q, de_q, line_start_q, frame_start_q;
    logic          hblank_d, vblank_d;

    assign ht_m1 = {1'b0, ha} + W1'(HPORCH - 1);
    assign vt_m1 = {1'b0, va} + W1'(VPORCH - 1);

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        x_wrap = 1'b0;
        y_wrap = 1'b0;
        if (en) begin
            if ({1'b0, x_q} >= ht_m1) begin
                x_d    = '0;
                x_wrap = 1'b1;
                if ({1'b0, y_q} >= vt_m1) begin
                    y_d    = '0;
                    y_wrap = 1'b1;
                end else begin
                    y_d = y_q + CW'(1);
                end
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    assign frame_wrap = x_wrap & y_wrap;

`ifdef VTG_RUNTIME_CFG_EN
    logic [CW-1:0] ha_q, va_q, pend_ha_q, pend_va_q;
    logic          pend_q, applied_q, rdy_q, xfer, apply;

    assign xfer  = cfg_valid & rdy_q;
    assign apply = frame_wrap & pend_q;
    assign ha    = ha_q;
    assign va    = va_q;
    assign ha_d  = apply ? pend_ha_q : ha_q;
    assign va_d  = apply ? pend_va_q : va_q;
    assign cfg_ready = rdy_q;

    // The slot reopens one cycle after the new sizes take effect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ha_q      <= CW'(H_ACTIVE);
            va_q      <= CW'(V_ACTIVE);
            pend_ha_q <= '0;
            pend_va_q <= '0;
            pend_q    <= 1'b0;
            applied_q <= 1'b0;
            rdy_q     <= 1'b1;
        end else begin
            ha_q      <= ha_d;
            va_q      <= va_d;
            applied_q <= apply;
            if (apply) begin
                pend_q <= 1'b0;
            end
            if (xfer) begin
                pend_q    <= 1'b1;
                pend_ha_q <= (cfg_h_active == '0) ? CW'(1) : cfg_h_active;
                pend_va_q <= (cfg_v_active == '0) ? CW'(1) : cfg_v_active;
                rdy_q     <= 1'b0;
            end else if (applied_q) begin
                rdy_q <= 1'b1;
            end
        end
    end
`else
    assign ha   = CW'(H_ACTIVE);
    assign va   = CW'(V_ACTIVE);
    assign ha_d = ha;
    assign va_d = va;
`endif

    assign hs_beg   = {1'b0, ha_d} + W1'(H_FP);
    assign hs_end   = hs_beg + W1'(H_SYNC);
    assign vs_beg   = {1'b0, va_d} + W1'(V_FP);
    assign vs_end   = vs_beg + W1'(V_SYNC);
    assign hblank_d = (x_d >= ha_d);
    assign vblank_d = (y_d >= va_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q           <= CW'(HT0 - 1);
            y_q           <= CW'(VT0 - 1);
            hsync_q       <= ~HS_ACT;
            vsync_q       <= ~VS_ACT;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= (({1'b0, x_d} >= hs_beg) && ({1'b0, x_d} < hs_end)) ? HS_ACT : ~HS_ACT;
            vsync_q       <= (({1'b0, y_d} >= vs_beg) && ({1'b0, y_d} < vs_end)) ? VS_ACT : ~VS_ACT;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            de_q          <= ~hblank_d & ~vblank_d;
            line_start_q  <= x_wrap;
            frame_start_q <= frame_wrap;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a frame-position model predicts every sample,
// a separate monitor compares DUT outputs and per-frame de counts.
`timescale 1ns/1ps
module tb_video_timing_gen;
    localparam int CW  = 8;
    localparam int HA0 = 4, HFP = 1, HSY = 2, HBP = 1;
    localparam int VA0 = 3, VFP = 1, VSY = 1, VBP = 1;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic hs, vs, hb, vb, de, ls, fs, rdy;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic [CW-1:0] x, y;
    logic          hsync, vsync, hblank, vblank, de, line_start, frame_start;
`ifdef VTG_RUNTIME_CFG_EN
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_h_active = '0;
    logic [CW-1:0] cfg_v_active = '0;
`endif

    video_timing_gen #(
        .CW(CW), .H_ACTIVE(HA0), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA0), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HSYNC_POL(1), .VSYNC_POL(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .x(x), .y(y),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de),
        .line_start(line_start), .frame_start(frame_start)
`ifdef VTG_RUNTIME_CFG_EN
        , .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_active(cfg_h_active), .cfg_v_active(cfg_v_active)
`endif
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   de_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model: position t within the frame, current and pending active sizes.
    int m_t, m_ha, m_va, m_pha, m_pva;
    bit m_pend, m_rdy, m_ret, m_full;

    function automatic obs_t predict(bit stepped);
        obs_t o;
        int ht = m_ha + HFP + HSY + HBP;
        int xx = m_t % ht;
        int yy = m_t / ht;
        o.x   = CW'(xx);
        o.y   = CW'(yy);
        o.hb  = (xx >= m_ha);
        o.vb  = (yy >= m_va);
        o.de  = !o.hb && !o.vb;
        o.hs  = (xx >= m_ha + HFP) && (xx < m_ha + HFP + HSY);
        o.vs  = (yy >= m_va + VFP) && (yy < m_va + VFP + VSY);
        o.ls  = stepped && (xx == 0);
        o.fs  = stepped && (m_t == 0);
        o.rdy = m_rdy;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d hs=%b vs=%b hb=%b vb=%b de=%b ls=%b fs=%b rdy=%b",
                         o.x, o.y, o.hs, o.vs, o.hb, o.vb, o.de, o.ls, o.fs, o.rdy);
    endfunction

    task automatic model_reset();
        m_ha   = HA0;
        m_va   = VA0;
        m_t    = (HA0 + HFP + HSY + HBP) * (VA0 + VFP + VSY + VBP) - 1;
        m_pend = 0;
        m_rdy  = 1;
        m_ret  = 0;
        m_full = 0;
    endtask

    task automatic model_edge(bit e, bit cv, int ch, int cvv);
        bit old_pend = m_pend;
        bit old_rdy  = m_rdy;
        int fsz = (m_ha + HFP + HSY + HBP) * (m_va + VFP + VSY + VBP);
        if (m_ret) m_rdy = 1;
        m_ret = 0;
        if (e) begin
            m_t++;
            if (m_t == fsz) begin
                m_t = 0;
                if (m_full) de_q.push_back(m_ha * m_va);
                m_full = 1;
                if (old_pend) begin
                    m_ha   = m_pha;
                    m_va   = m_pva;
                    m_pend = 0;
                    m_ret  = 1;
                end
            end
        end
        if (cv && old_rdy) begin
            m_pend = 1;
            m_pha  = (ch == 0) ? 1 : ch;
            m_pva  = (cvv == 0) ? 1 : cvv;
            m_rdy  = 0;
        end
        exp_q.push_back(predict(e));
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic step(bit e, bit cv = 0, int ch = 0, int cvv = 0);
        en = e;
`ifdef VTG_RUNTIME_CFG_EN
        cfg_valid    = cv;
        cfg_h_active = CW'(ch);
        cfg_v_active = CW'(cvv);
`endif
        model_edge(e, cv, ch, cvv);
        @(negedge clk);
    endtask

    task automatic do_reset();
        model_reset();
        exp_q.push_back(predict(0));
        #2 reset_n = 1'b0;
        en = 1'($urandom_range(0, 1));
`ifdef VTG_RUNTIME_CFG_EN
        cfg_valid = 1'b0;
`endif
        repeat (2) begin
            exp_q.push_back(predict(0));
            @(negedge clk);
        end
        reset_n = 1'b1;
    endtask

    // Monitor
    initial begin
        obs_t act, exp;
        bit   counting = 0;
        int   de_cnt   = 0;
        int   want;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            act.x  = x;          act.y  = y;
            act.hs = hsync;      act.vs = vsync;
            act.hb = hblank;     act.vb = vblank;
            act.de = de;         act.ls = line_start;
            act.fs = frame_start;
`ifdef VTG_RUNTIME_CFG_EN
            act.rdy = cfg_ready;
`else
            act.rdy = 1'b1;
`endif
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sample @%0t: no prediction queued, got %s", $time, fmt(act));
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("FAIL outputs @%0t: got %s want %s", $time, fmt(act), fmt(exp));
                end
            end
            if (!reset_n) begin
                counting = 0;
            end else if (en) begin
                if (act.fs) begin
                    if (counting) begin
                        total++;
                        if (de_q.size() == 0) begin
                            bad++;
                            $display("FAIL de_count @%0t: got %0d, no frame expected", $time, de_cnt);
                        end else begin
                            want = de_q.pop_front();
                            if (de_cnt != want) begin
                                bad++;
                                $display("FAIL de_count @%0t: got %0d want %0d", $time, de_cnt, want);
                            end
                        end
                    end
                    counting = 1;
                    de_cnt   = int'(act.de);
                end else if (counting) begin
                    de_cnt += int'(act.de);
                end
            end
        end
    end

    // Driver
    initial begin
        bit e, cv;
        int ch, cvv, guard;
        reset_n = 1'b1;
        en      = 1'b0;
        do_reset();

        repeat (96) step(1);
        guard = 0;
        while (m_t != 10 && guard < 100) begin step(1); guard++; end
        repeat (10) step(0);
        step(1);
        guard = 0;
        while (m_t != 22 && guard < 100) begin step(1); guard++; end
        do_reset();
        repeat (50) step(1);

`ifdef VTG_RUNTIME_CFG_EN
        do_reset();
        repeat (10) step(1);
        step(1, 1, 2, 2);
        repeat (3) step(1);
        step(1, 1, 3, 3);
        repeat (150) step(1);
`endif

        repeat (1500) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                e = ($urandom_range(0, 3) != 0);
`ifdef VTG_RUNTIME_CFG_EN
                cv = ($urandom_range(0, 5) == 0);
`else
                cv = 0;
`endif
                ch  = $urandom_range(0, 5);
                cvv = $urandom_range(0, 5);
                step(e, cv, ch, cvv);
            end
        end

        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  CW, 12, counter width in bits.
  H_ACTIVE, 400, active pixels per line.
  H_FP, 8, horizontal front porch in pixels.
  H_SYNC, 1, hsync length in pixels.
  H_BP, 14, horizontal back porch in pixels.
  V_ACTIVE, 360, active lines per frame.
  V_FP, 14, vertical front porch in lines.
  V_SYNC, 1, vsync length in lines.
  V_BP, 19, vertical back porch in lines.
  HSYNC_POL, 1, 1 = active-high, 0 = active-low.
  VSYNC_POL, 1, 1 = active-high, 0 = active-low.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  clk, in, 1, pixel clock.
  reset_n, in, 1, asynchronous active-low reset.
  en, in, 1, advance timing by one pixel when high.
  x, out, CW, current pixel column.
  y, out, CW, current line.
  hsync, out, 1, horizontal sync at HSYNC_POL.
  vsync, out, 1, vertical sync at VSYNC_POL.
  hblank, out, 1, x >= active width.
  vblank, out, 1, y >= active height.
  de, out, 1, !hblank && !vblank.
  line_start, out, 1, one-cycle pulse when x becomes 0.
  frame_start, out, 1, one-cycle pulse when (x,y) becomes (0,0).
  cfg_valid, in, 1, runtime config offer.
  cfg_ready, out, 1, config slot free.
  cfg_h_active, in, CW, runtime active width.
  cfg_v_active, in, CW, runtime active height.
  The cfg_* ports exist only with VTG_RUNTIME_CFG_EN.
REQ-003 Elaboration SHALL fail if any porch or sync parameter is 0, or if either total exceeds 2**CW.

Function
REQ-004 Totals SHALL be HT = HA+H_FP+H_SYNC+H_BP and VT = VA+V_FP+V_SYNC+V_BP, where HA/VA are the current active sizes.
REQ-005 On each clk edge with en=1, x SHALL increment; at x=HT-1 it SHALL wrap to 0 and y SHALL increment; at y=VT-1 together with that wrap, y SHALL wrap to 0.
REQ-006 With en=0, x, y and all outputs SHALL hold, and line_start and frame_start SHALL be 0.
REQ-007 All outputs SHALL be registers decoded from the next (x,y), so every output aligns with the x,y value in the same cycle, with zero latency.
REQ-008 hsync SHALL be active for x in [HA+H_FP, HA+H_FP+H_SYNC); vsync SHALL be active for whole lines y in [VA+V_FP, VA+V_FP+V_SYNC); both SHALL be at the inactive level otherwise.
REQ-009 hblank, vblank and de SHALL follow REQ-002 exactly; de SHALL be 1 for exactly HA*VA cycles per frame.
REQ-010 line_start SHALL pulse on every x wrap to 0; frame_start SHALL pulse only when line_start coincides with y=0.
REQ-011 Counter arithmetic SHALL be CW-bit unsigned; no count SHALL ever reach HT or VT.

Reset
REQ-012 Asserting reset_n=0 SHALL act immediately and asynchronously, setting x=HT-1 and y=VT-1 using the parameter sizes.
REQ-013 Reset values SHALL be: hblank=1, vblank=1, de=0, line_start=0, frame_start=0, hsync and vsync inactive, and cfg_ready=1.
REQ-014 The first enabled edge after release SHALL produce x=0, y=0, frame_start=1 and line_start=1.
REQ-015 A reset mid-frame SHALL discard any pending config and revert HA/VA to H_ACTIVE/V_ACTIVE.

Configuration
REQ-016 With VTG_RUNTIME_CFG_EN defined, the SHALL behaviour is:
  A transfer occurs when cfg_valid=1 and cfg_ready=1; the sizes are captured into a pending register and cfg_ready drops to 0.
  The pending sizes become HA/VA on the edge where (x,y) wraps to (0,0), never mid-frame.
  cfg_ready returns to 1 on the following cycle.
  A value of 0 is stored as 1.
  An offer accepted during the wrap cycle applies at the next frame.
REQ-017 Without VTG_RUNTIME_CFG_EN, the cfg_* ports and the pending logic SHALL be absent, and HA/VA SHALL be fixed at H_ACTIVE/V_ACTIVE.

Verification
Bench parameters are H 4/1/2/1 (HT=8) and V 3/1/1/1 (VT=6), both polarities 1.
REQ-018 Release reset with en=1: the first cycle is x=0, y=0, frame_start=1, de=1; the frame repeats every 48 cycles with exactly 12 de cycles.
REQ-019 Observe line 0: hsync=1 only at x=5 and x=6, hblank=1 for x=4..7, and line_start pulses every 8 cycles.
REQ-020 Observe vsync: it is 1 for all 8 cycles of y=4 only, and vblank=1 for y=3..5.
REQ-021 Hold en=0 for 10 cycles at x=2, y=1: all outputs hold, with no pulses; the counters resume at x=3 when en returns to 1.
REQ-022 Pulse reset_n low at x=6, y=2: outputs immediately take the REQ-013 reset values, with x=7 and y=5.
REQ-023 With VTG_RUNTIME_CFG_EN, offer cfg 2x2 mid-frame: cfg_ready=0 until the wrap; the next frame has HT=6, VT=5 and 4 de cycles; a second offer made while cfg_ready=0 is not accepted.
